mdu_seq_ctrl: RTL

- CPU-side controller for the HI/LO unit of the multicycle core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the control FSM through a valid/ready handshake.
- Runs an iterative one-bit-per-cycle multiply/divide engine, owns the architectural HI/LO registers, and returns MFHI/MFLO data.
- The control FSM stalls on op_ready instead of relying on single-cycle combinational mul/div.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_iter_core.sv | 112 +++++++++++
 rtl/mdu_seq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: request opcodes,
// controller states and the default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative one-bit-per-cycle multiply/divide datapath. Operates on operand
// magnitudes and presents sign-corrected HI/LO combinationally once the last
// iteration has completed. o_fin flags the edge on which the last iteration runs.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN,
    parameter int unsigned ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_is_div,
    input  logic            i_is_signed,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_fin
);

    localparam int unsigned     CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

    logic                r_run;
    logic [CW-1:0]       r_cnt;
    logic                r_div;
    logic                r_bzero;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_m;       // multiplicand (mul) or divisor magnitude (div)
    logic [XLEN-1:0]     r_q;       // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]     r_rem;     // partial remainder, always below the divisor
    logic [2*XLEN-1:0]   r_acc;     // product accumulator, multiplier in low half

    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_shift;
    logic                w_ge;
    logic [2*XLEN-1:0]   w_prod;

    assign w_abs_a = (i_is_signed && i_a[XLEN-1]) ? -i_a : i_a;
    assign w_abs_b = (i_is_signed && i_b[XLEN-1]) ? -i_b : i_b;

    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_shift = {r_rem, r_q[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    assign o_fin   = r_run && (r_cnt == LAST);

    // Load magnitudes on start, then run one shift-add and one restoring step per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_bzero <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a     <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_acc   <= '0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_div   <= i_is_div;
            r_bzero <= (i_b == '0);
            r_neg_q <= i_is_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_r <= i_is_signed && i_a[XLEN-1];
            r_a     <= i_a;
            r_m     <= i_is_div ? w_abs_b : w_abs_a;
            r_q     <= w_abs_a;
            r_rem   <= '0;
            r_acc   <= {{XLEN{1'b0}}, w_abs_b};
        end else if (r_run) begin
            // Both engines advance every step; the mode bit selects which result is used
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
            if (w_ge) begin
                r_rem <= XLEN'(w_shift - {1'b0, r_m});
                r_q   <= {r_q[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[XLEN-1:0];
                r_q   <= {r_q[XLEN-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
            end
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;

    // Sign correction of the finished magnitudes; divide-by-zero bypasses it
    always_comb begin
        o_hi = w_prod[2*XLEN-1:XLEN];
        o_lo = w_prod[XLEN-1:0];
        if (r_div) begin
            if (r_bzero) begin
                o_hi = r_a;
                o_lo = '1;
            end else begin
                o_hi = r_neg_r ? -r_rem : r_rem;
                o_lo = r_neg_q ? -r_q : r_q;
            end
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// HI/LO unit controller: valid/ready request handshake, architectural HI/LO
// registers, MTHI/MTLO/MFHI/MFLO paths and sequencing of the iterative core.
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN,
    parameter int unsigned ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            op_ready,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_q,
    output logic [XLEN-1:0] lo_q
);

    mdu_state_e      r_state;
    logic            r_op_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_valid;
    logic [XLEN-1:0] r_rd_data;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    mdu_op_e         w_op;
    logic            w_accept;
    logic            w_start;
    logic [XLEN-1:0] w_core_hi;
    logic [XLEN-1:0] w_core_lo;
    logic            w_core_fin;

    assign w_op     = mdu_op_e'(op_code);
    assign w_accept = op_valid && r_op_ready;
    assign w_start  = w_accept && !op_code[2];

    mdu_iter_core #(
        .XLEN (XLEN),
        .ITER (ITER)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_is_div    (op_code[1]),
        .i_is_signed (!op_code[0]),
        .i_a         (rs_data),
        .i_b         (rt_data),
        .o_hi        (w_core_hi),
        .o_lo        (w_core_lo),
        .o_fin       (w_core_fin)
    );

    // Request FSM with registered handshake, status and HI/LO outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_MTHI: r_hi <= rs_data;
                            OP_MTLO: r_lo <= rs_data;
                            OP_MFHI: begin
                                r_rd_data  <= r_hi;
                                r_rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                r_rd_data  <= r_lo;
                                r_rd_valid <= 1'b1;
                            end
                            default: begin
                                r_state    <= CALC;
                                r_busy     <= 1'b1;
                                r_op_ready <= 1'b0;
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (w_core_fin) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi       <= w_core_hi;
                    r_lo       <= w_core_lo;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_op_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_op_ready <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready = r_op_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign hi_q     = r_hi;
    assign lo_q     = r_lo;

endmodule
